// File: rtl/useq_host_bridge.sv
// ---------------------------------------------------------------------------
// useq_host_bridge
//
// Host-side neighbour of the useq core. Turns a valid/ready byte stream into
// single-cycle write pulses on the core's host FIFO port, and turns bytes
// popped from that FIFO into a valid/ready output stream. Only one FIFO op is
// in flight at a time. The core's fifo flags are looked at only in IDLE, and
// a GAP period after every op gives them time to settle.
//
// Parameters
//   GAP_CYCLES  idle cycles after each FIFO op (values below 1 act as 1)
//   WR_FIRST    which op wins the first time write and read are both possible
//               after reset (1 = write)
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   s_data/s_valid      host byte to push into the core FIFO
//   s_ready             combinational: byte accepted this cycle
//   m_data/m_valid      byte popped from the core FIFO, held until m_ready
//   m_ready             consumer takes m_data
//   fifo_empty/full     core FIFO flags
//   fifo_out            core FIFO data, valid the cycle after read_fifo
//   write_fifo          registered one-cycle write pulse to the core
//   read_fifo           registered one-cycle read pulse to the core
//   fifo_in             registered write data, valid with write_fifo
//   busy                FSM is not in IDLE
// ---------------------------------------------------------------------------
module useq_host_bridge #(
  parameter int GAP_CYCLES = 1,
  parameter bit WR_FIRST   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  input  logic [7:0] fifo_out,
  output logic       write_fifo,
  output logic       read_fifo,
  output logic [7:0] fifo_in,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GAP_W   = $clog2(GAP_EFF + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_EFF);

  state_e           state_q,      state_d;
  logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;
  logic             tog_q,        tog_d;
  logic             write_fifo_q, write_fifo_d;
  logic             read_fifo_q,  read_fifo_d;
  logic [7:0]       fifo_in_q,    fifo_in_d;
  logic [7:0]       m_data_q,     m_data_d;
  logic             m_valid_q,    m_valid_d;

  logic wr_ok;
  logic rd_ok;

  // A read is only worth doing if the single-entry output register is free.
  assign wr_ok = s_valid & ~fifo_full;
  assign rd_ok = ~fifo_empty & ~m_valid_q;

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    tog_d        = tog_q;
    write_fifo_d = 1'b0;
    read_fifo_d  = 1'b0;
    fifo_in_d    = fifo_in_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    s_ready      = 1'b0;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // No op is started while reset is held, so s_ready never claims a
        // byte that the reset is about to discard.
        if (rst_n) begin
          if (wr_ok && (!rd_ok || tog_q)) begin
            s_ready      = 1'b1;
            fifo_in_d    = s_data;
            write_fifo_d = 1'b1;
            state_d      = ST_WR;
            if (rd_ok) tog_d = ~tog_q;
          end else if (rd_ok) begin
            read_fifo_d = 1'b1;
            state_d     = ST_RD;
            if (wr_ok) tog_d = ~tog_q;
          end
        end
      end
      ST_WR: begin
        state_d   = ST_GAP;
        gap_cnt_d = GAP_LOAD;
      end
      ST_RD: begin
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        // fifo_out is valid now, one cycle after the read pulse.
        m_data_d  = fifo_out;
        m_valid_d = 1'b1;
        state_d   = ST_GAP;
        gap_cnt_d = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      tog_q        <= WR_FIRST;
      write_fifo_q <= 1'b0;
      read_fifo_q  <= 1'b0;
      fifo_in_q    <= 8'h00;
      m_data_q     <= 8'h00;
      m_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      tog_q        <= tog_d;
      write_fifo_q <= write_fifo_d;
      read_fifo_q  <= read_fifo_d;
      fifo_in_q    <= fifo_in_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
    end
  end

  assign write_fifo = write_fifo_q;
  assign read_fifo  = read_fifo_q;
  assign fifo_in    = fifo_in_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
